// File: rtl/cd_pkg.sv
// Shared definitions for the cd_param datapath: ALU opcodes, instruction field
// positions, register-address width and the next-PC source encoding.
package cd_pkg;

    localparam int REG_AW = 4;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 10;
    localparam int RA1_MSB = 11;
    localparam int RA1_LSB = 8;
    localparam int RA2_MSB = 7;
    localparam int RA2_LSB = 4;
    localparam int WA3_MSB = 3;
    localparam int WA3_LSB = 0;
    localparam int IMM_MSB = 11;
    localparam int IMM_LSB = 4;
    localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

    localparam logic [2:0] ALU_PASS = 3'b000;
    localparam logic [2:0] ALU_NOT  = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_SUB  = 3'b011;
    localparam logic [2:0] ALU_AND  = 3'b100;
    localparam logic [2:0] ALU_OR   = 3'b101;
    localparam logic [2:0] ALU_NEGA = 3'b110;
    localparam logic [2:0] ALU_NEGB = 3'b111;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_JUMP,
        PC_CALL,
        PC_RET
    } pc_src_e;

endpackage

// File: rtl/pila_retorno.sv
// pila_retorno: DEPTH x PC_W return-address LIFO. Pop wins over push; a push
// when full or a pop when empty leaves sp unchanged (the caller flags the fault).
module pila_retorno #(
    parameter  int DEPTH = 8,
    parameter  int PC_W  = 10,
    localparam int SP_W  = $clog2(DEPTH) + 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            push_i,
    input  logic            pop_i,
    input  logic [PC_W-1:0] din_i,
    output logic [PC_W-1:0] dout_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [SP_W-1:0] sp_o
);

    logic [PC_W-1:0] mem_q [DEPTH];
    logic [SP_W-1:0] sp_q, sp_d;
    logic [SP_W-2:0] wr_idx, rd_idx;
    logic            do_push, do_pop;

    // DEPTH is a power of two, so sp == DEPTH is exactly the MSB being set.
    assign full_o  = sp_q[SP_W-1];
    assign empty_o = (sp_q == '0);
    assign sp_o    = sp_q;

    assign wr_idx  = sp_q[SP_W-2:0];
    assign rd_idx  = wr_idx - (SP_W-1)'(1);
    assign dout_o  = mem_q[rd_idx];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & ~pop_i & ~full_o;

    always_comb begin
        // NOTE: default assignment first so every path drives sp_d; no latch.
        sp_d = sp_q;
        if (do_pop) begin
            sp_d = sp_q - SP_W'(1);
        end else if (do_push) begin
            sp_d = sp_q + SP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking for all clocked state so every register samples pre-edge values.
        if (!reset) begin
            sp_q <= '0;
        end else begin
            sp_q <= sp_d;
        end
    end

    // NOTE: storage arrays carry no reset; only the pointer is reset, which makes old entries unreachable.
    always_ff @(posedge clk) begin
        if (reset && do_push) begin
            mem_q[wr_idx] <= din_i;
        end
    end

endmodule

// File: rtl/cd_param.sv
// cd_param: parametrised single-cycle datapath with a hardware return stack and
// sticky stack-fault flags. Define CD_CARRY_EN to build the carry flag; otherwise c = 0.
module cd_param
    import cd_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int PC_W        = 10,
    parameter int STACK_DEPTH = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     instr,
    input  logic            s_inc,
    input  logic            s_inm,
    input  logic            we3,
    input  logic            wez,
    input  logic            wec,
    input  logic            s_call,
    input  logic            s_ret,
    input  logic [2:0]      op_alu,
    output logic [PC_W-1:0] pc,
    output logic [5:0]      opcode,
    output logic            z,
    output logic            c,
    output logic            stack_ovf,
    output logic            stack_udf
);

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int NREGS = 1 << REG_AW;

    logic [REG_AW-1:0] ra1, ra2, wa3;
    logic [IMM_W-1:0]  imm;
    logic [PC_W-1:0]   target;

    assign opcode = instr[OPC_MSB:OPC_LSB];
    assign ra1    = instr[RA1_MSB:RA1_LSB];
    assign ra2    = instr[RA2_MSB:RA2_LSB];
    assign wa3    = instr[WA3_MSB:WA3_LSB];
    assign imm    = instr[IMM_MSB:IMM_LSB];
    assign target = instr[PC_W-1:0];

    // Register file: r0 is never written and is forced to read zero.
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] rd1, rd2, wb_data;

    assign rd1 = (ra1 == '0) ? '0 : rf_q[ra1];
    assign rd2 = (ra2 == '0) ? '0 : rf_q[ra2];

    always_ff @(posedge clk) begin
        if (reset && we3 && (wa3 != '0)) begin
            rf_q[wa3] <= wb_data;
        end
    end

    logic [DATA_W-1:0] alu_res;
`ifdef CD_CARRY_EN
    logic [DATA_W:0]   sum_ext;
    logic              alu_cy;

    assign sum_ext = {1'b0, rd1} + {1'b0, rd2};
`endif

    always_comb begin
        alu_res = '0;
`ifdef CD_CARRY_EN
        alu_cy  = 1'b0;
`endif
        case (op_alu)
            ALU_PASS: alu_res = rd1;
            ALU_NOT:  alu_res = ~rd1;
`ifdef CD_CARRY_EN
            ALU_ADD: begin
                alu_res = sum_ext[DATA_W-1:0];
                alu_cy  = sum_ext[DATA_W];
            end
            ALU_SUB: begin
                alu_res = rd1 - rd2;
                alu_cy  = (rd1 < rd2);
            end
`else
            ALU_ADD:  alu_res = rd1 + rd2;
            ALU_SUB:  alu_res = rd1 - rd2;
`endif
            ALU_AND:  alu_res = rd1 & rd2;
            ALU_OR:   alu_res = rd1 | rd2;
            ALU_NEGA: alu_res = '0 - rd1;
            ALU_NEGB: alu_res = '0 - rd2;
            default:  alu_res = '0;
        endcase
    end

    always_comb begin
        wb_data = alu_res;
        if (s_inm) begin
            wb_data              = '0;
            wb_data[IMM_W-1:0]   = imm;
        end
    end

    // Next-PC selection: return beats call beats sequential/jump.
    pc_src_e         pc_src;
    logic [PC_W-1:0] pc_q, pc_d, pc_plus1, stk_top;
    logic            stk_full, stk_empty;
    logic [SP_W-1:0] unused_stk_sp;

    always_comb begin
        if (s_ret) begin
            pc_src = PC_RET;
        end else if (s_call) begin
            pc_src = PC_CALL;
        end else if (s_inc) begin
            pc_src = PC_SEQ;
        end else begin
            pc_src = PC_JUMP;
        end
    end

    assign pc_plus1 = pc_q + PC_W'(1);

    always_comb begin
        pc_d = pc_plus1;
        case (pc_src)
            PC_RET:  pc_d = stk_empty ? pc_plus1 : stk_top;
            PC_CALL: pc_d = target;
            PC_JUMP: pc_d = target;
            PC_SEQ:  pc_d = pc_plus1;
            default: pc_d = pc_plus1;
        endcase
    end

    pila_retorno #(
        .DEPTH (STACK_DEPTH),
        .PC_W  (PC_W)
    ) u_stack (
        .clk     (clk),
        .reset   (reset),
        .push_i  (pc_src == PC_CALL),
        .pop_i   (pc_src == PC_RET),
        .din_i   (pc_plus1),
        .dout_o  (stk_top),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .sp_o    (unused_stk_sp)
    );

    logic z_q, z_d;
    logic ovf_q, ovf_d, udf_q, udf_d;

    assign z_d   = wez ? (alu_res == '0) : z_q;
    assign ovf_d = ovf_q | ((pc_src == PC_CALL) & stk_full);
    assign udf_d = udf_q | ((pc_src == PC_RET) & stk_empty);

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q  <= '0;
            z_q   <= 1'b0;
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            z_q   <= z_d;
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

`ifdef CD_CARRY_EN
    logic c_q, c_d;

    assign c_d = wec ? alu_cy : c_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            c_q <= 1'b0;
        end else begin
            c_q <= c_d;
        end
    end

    assign c = c_q;
`else
    logic unused_wec;

    assign unused_wec = wec;
    assign c          = 1'b0;
`endif

    assign pc        = pc_q;
    assign z         = z_q;
    assign stack_ovf = ovf_q;
    assign stack_udf = udf_q;

endmodule

// File: tb/tb_cd_param.sv
// Self-checking bench for cd_param: a behavioural model pushes expected state to a
// scoreboard each cycle; the DUT state is popped and compared after the clock edge.
module tb_cd_param;
    import cd_pkg::*;

    localparam int DW = 8;
    localparam int PW = 10;
    localparam int SD = 2;
`ifdef CD_CARRY_EN
    localparam logic EXP_CY = 1'b1;
`else
    localparam logic EXP_CY = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [15:0]   instr;
    logic          s_inc, s_inm, we3, wez, wec, s_call, s_ret;
    logic [2:0]    op_alu;
    logic [PW-1:0] pc;
    logic [5:0]    opcode;
    logic          z, c, stack_ovf, stack_udf;

    always #5 clk = ~clk;

    cd_param #(
        .DATA_W      (DW),
        .PC_W        (PW),
        .STACK_DEPTH (SD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .instr     (instr),
        .s_inc     (s_inc),
        .s_inm     (s_inm),
        .we3       (we3),
        .wez       (wez),
        .wec       (wec),
        .s_call    (s_call),
        .s_ret     (s_ret),
        .op_alu    (op_alu),
        .pc        (pc),
        .opcode    (opcode),
        .z         (z),
        .c         (c),
        .stack_ovf (stack_ovf),
        .stack_udf (stack_udf)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    logic [DW-1:0] m_rf [16];
    logic [PW-1:0] m_pc;
    logic [PW-1:0] m_stk [$];
    logic          m_z, m_c, m_ovf, m_udf;

    typedef struct {
        string         tag;
        logic [PW-1:0] pc;
        logic [5:0]    opc;
        logic          z, c, ovf, udf;
    } exp_t;

    exp_t sb_q [$];

    task automatic step(input string tag, input logic rst_n, input logic [15:0] ins,
                        input logic inc, input logic inm, input logic w3, input logic wz,
                        input logic wc, input logic call, input logic ret, input logic [2:0] op);
        exp_t          e;
        logic [DW-1:0] a, b, res;
        logic [DW:0]   full;
        logic          cy;
        logic [PW-1:0] nxt;
        logic [3:0]    ra, rb, rd;

        reset  = rst_n;
        instr  = ins;
        s_inc  = inc;
        s_inm  = inm;
        we3    = w3;
        wez    = wz;
        wec    = wc;
        s_call = call;
        s_ret  = ret;
        op_alu = op;

        if (!rst_n) begin
            m_pc  = '0;
            m_stk.delete();
            m_z   = 1'b0;
            m_c   = 1'b0;
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            ra = ins[11:8];
            rb = ins[7:4];
            rd = ins[3:0];
            a  = (ra == 4'd0) ? '0 : m_rf[ra];
            b  = (rb == 4'd0) ? '0 : m_rf[rb];
            cy = 1'b0;
            case (op)
                ALU_PASS: res = a;
                ALU_NOT:  res = ~a;
                ALU_ADD: begin
                    full = DW'(a) + DW'(b) + (DW+1)'(0);
                    full = {1'b0, a} + {1'b0, b};
                    res  = full[DW-1:0];
                    cy   = full[DW];
                end
                ALU_SUB: begin
                    res = a - b;
                    cy  = (a < b);
                end
                ALU_AND:  res = a & b;
                ALU_OR:   res = a | b;
                ALU_NEGA: res = 8'd0 - a;
                default:  res = 8'd0 - b;
            endcase
            if (w3 && rd != 4'd0) m_rf[rd] = inm ? ins[11:4] : res;
            if (wz) m_z = (res == '0);
            if (wc) m_c = cy & EXP_CY;

            nxt = m_pc + 10'd1;
            if (ret) begin
                if (m_stk.size() > 0) begin
                    m_pc = m_stk.pop_back();
                end else begin
                    m_pc  = nxt;
                    m_udf = 1'b1;
                end
            end else if (call) begin
                if (m_stk.size() < SD) m_stk.push_back(nxt);
                else                   m_ovf = 1'b1;
                m_pc = ins[PW-1:0];
            end else begin
                m_pc = inc ? nxt : ins[PW-1:0];
            end
        end

        e.tag = tag;
        e.pc  = m_pc;
        e.opc = ins[15:10];
        e.z   = m_z;
        e.c   = m_c;
        e.ovf = m_ovf;
        e.udf = m_udf;
        sb_q.push_back(e);

        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check({e.tag, ".pc"},  32'(pc),        32'(e.pc));
        check({e.tag, ".opc"}, 32'(opcode),    32'(e.opc));
        check({e.tag, ".z"},   32'(z),         32'(e.z));
        check({e.tag, ".c"},   32'(c),         32'(e.c));
        check({e.tag, ".ovf"}, 32'(stack_ovf), 32'(e.ovf));
        check({e.tag, ".udf"}, 32'(stack_udf), 32'(e.udf));
        @(negedge clk);
    endtask

    // Reset with every enable asserted to show reset overrides them.
    task automatic do_rst(input string tag);
        step(tag, 1'b0, {6'h21, 10'd20}, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, ALU_ADD);
    endtask

    task automatic nop(input string tag);
        step(tag, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_PASS);
    endtask

    task automatic li(input string tag, input logic [7:0] v, input logic [3:0] rd);
        step(tag, 1'b1, {4'h0, v, rd}, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, ALU_PASS);
    endtask

    task automatic alu(input string tag, input logic [2:0] op, input logic [3:0] ra,
                       input logic [3:0] rb, input logic [3:0] rd);
        step(tag, 1'b1, {4'hC, ra, rb, rd}, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, op);
    endtask

    task automatic jmp(input string tag, input logic [PW-1:0] t);
        step(tag, 1'b1, {6'h20, t}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ALU_PASS);
    endtask

    task automatic call(input string tag, input logic [PW-1:0] t);
        step(tag, 1'b1, {6'h21, t}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ALU_PASS);
    endtask

    task automatic ret(input string tag);
        step(tag, 1'b1, 16'h8C00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, ALU_PASS);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] va, vb;
        logic [2:0] rop;

        reset = 1'b0; instr = '0; s_inc = 1'b0; s_inm = 1'b0; we3 = 1'b0;
        wez = 1'b0; wec = 1'b0; s_call = 1'b0; s_ret = 1'b0; op_alu = ALU_PASS;
        for (int i = 0; i < 16; i++) m_rf[i] = '0;
        @(negedge clk);

        do_rst("rst0");
        do_rst("rst1");
        check("rst_pc",  32'(pc),        32'd0);
        check("rst_z",   32'(z),         32'd0);
        check("rst_c",   32'(c),         32'd0);
        check("rst_ovf", 32'(stack_ovf), 32'd0);
        check("rst_udf", 32'(stack_udf), 32'd0);
        nop("fetch0");
        check("fetch0_pc", 32'(pc), 32'd1);

        li("li_f0", 8'hF0, 4'd1);
        li("li_10", 8'h10, 4'd2);
        alu("add_wrap", ALU_ADD, 4'd1, 4'd2, 4'd3);
        check("add_z", 32'(z), 32'd1);
        check("add_c", 32'(c), 32'(EXP_CY));
        alu("r3_zero", ALU_PASS, 4'd3, 4'd0, 4'd5);
        check("r3_zero_z", 32'(z), 32'd1);

        li("li_3", 8'h03, 4'd1);
        li("li_5", 8'h05, 4'd2);
        alu("sub_borrow", ALU_SUB, 4'd1, 4'd2, 4'd4);
        check("sub_z", 32'(z), 32'd0);
        check("sub_c", 32'(c), 32'(EXP_CY));
        li("li_2", 8'h02, 4'd6);
        alu("fe_plus2", ALU_ADD, 4'd4, 4'd6, 4'd7);
        check("fe_plus2_z", 32'(z), 32'd1);

        li("li_r0", 8'h55, 4'd0);
        alu("r0_read", ALU_PASS, 4'd0, 4'd0, 4'd8);
        check("r0_read_z", 32'(z), 32'd1);

        for (int i = 0; i < 16; i++) begin
            va  = 8'($urandom_range(0, 255));
            vb  = (i % 4 == 0) ? 8'h00 : ((i % 4 == 1) ? va : 8'($urandom_range(0, 255)));
            rop = 3'(i % 8);
            li("rnd_la", va, 4'd9);
            li("rnd_lb", vb, 4'd10);
            alu("rnd_op", rop, 4'd9, 4'd10, 4'd11);
            alu("rnd_rb", ALU_PASS, 4'd11, 4'd0, 4'd12);
        end

        jmp("jmp5", 10'd5);
        check("jmp5_pc", 32'(pc), 32'd5);
        call("call20", 10'd20);
        call("call40", 10'd40);
        check("call40_pc", 32'(pc), 32'd40);
        ret("ret21");
        check("ret21_pc", 32'(pc), 32'd21);
        ret("ret6");
        check("ret6_pc", 32'(pc), 32'd6);
        ret("ret_udf");
        check("ret_udf_pc",  32'(pc),        32'd7);
        check("ret_udf_flg", 32'(stack_udf), 32'd1);

        do_rst("rst_ovf");
        jmp("jmp100", 10'd100);
        call("ovf_c1", 10'd200);
        call("ovf_c2", 10'd300);
        call("ovf_c3", 10'd400);
        check("ovf_c3_pc",  32'(pc),        32'd400);
        check("ovf_c3_flg", 32'(stack_ovf), 32'd1);
        ret("ovf_r1");
        check("ovf_r1_pc", 32'(pc), 32'd201);
        ret("ovf_r2");
        check("ovf_r2_pc",  32'(pc),        32'd101);
        check("ovf_sticky", 32'(stack_ovf), 32'd1);

        do_rst("rst_sim");
        call("sim_call", 10'd500);
        step("sim_both", 1'b1, {6'h21, 10'd700}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, ALU_PASS);
        check("sim_both_pc",  32'(pc),        32'd1);
        check("sim_both_udf", 32'(stack_udf), 32'd0);
        ret("sim_empty");
        check("sim_empty_pc",  32'(pc),        32'd2);
        check("sim_empty_udf", 32'(stack_udf), 32'd1);

        do_rst("rst_disc0");
        call("disc_call", 10'd500);
        do_rst("rst_disc1");
        ret("disc_ret");
        check("disc_ret_pc",  32'(pc),        32'd1);
        check("disc_ret_udf", 32'(stack_udf), 32'd1);

        jmp("jmp_top", 10'd1023);
        nop("wrap_inc");
        check("wrap_inc_pc", 32'(pc), 32'd0);
        jmp("jmp_top2", 10'd1023);
        call("wrap_call", 10'd50);
        ret("wrap_ret");
        check("wrap_ret_pc", 32'(pc), 32'd0);

        check("sb_drain", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cd_param.md
# cd_param

Parametrised single-cycle CPU datapath, successor to the fixed 8-bit/10-bit datapath. Adds generic data width, a hardware return-address stack for subroutine call/return, and an optional carry flag. It also adds sticky stack-fault flags. Instruction memory is external: the block drives `pc` and consumes the combinational `instr` word; the control unit drives all select/enable inputs from `opcode`.

## Interface
Parameters:
- `DATA_W`, 8: register/ALU width; must be ≥ 8.
- `PC_W`, 10: program counter width; must be ≤ 10.
- `STACK_DEPTH`, 8: return-stack entries; must be a power of two, ≥ 2.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-low.
- `instr` in 16: instruction word at address `pc`.
- `s_inc` in 1: 1 = PC+1, 0 = jump to `instr[PC_W-1:0]`.
- `s_inm` in 1: 1 = write-back zero-extended immediate `instr[11:4]`, 0 = ALU result.
- `we3` in 1: register-file write enable.
- `wez` in 1: zero-flag load enable.
- `wec` in 1: carry-flag load enable.
- `s_call` in 1: push PC+1, jump to `instr[PC_W-1:0]`.
- `s_ret` in 1: pop PC from the stack.
- `op_alu` in 3: ALU operation.
- `pc` out PC_W: current program counter.
- `opcode` out 6: `instr[15:10]`.
- `z` out 1: zero flag.
- `c` out 1: carry flag.
- `stack_ovf` out 1: sticky overflow flag.
- `stack_udf` out 1: sticky underflow flag.

## Operation
- Register fields: ra1 = `instr[11:8]`, ra2 = `instr[7:4]`, wa3 = `instr[3:0]`.
- Register file: 16 × DATA_W. Reads are combinational; writes are synchronous.
- Register r0 always reads 0. Writes to r0 are discarded.
- ALU ops, with a = rd1 and b = rd2:
  - 000: a
  - 001: ~a
  - 010: a+b
  - 011: a−b
  - 100: a&b
  - 101: a|b
  - 110: −a
  - 111: −b
- ALU results are truncated to DATA_W.
- zero = (result == 0), computed on the truncated result.
- Carry for op 010: carry-out of the DATA_W+1-bit sum.
- Carry for op 011: borrow, 1 iff a < b unsigned.
- Carry for all other ops: 0.
- Next-PC priority:
  1. `s_ret`
  2. `s_call`
  3. `s_inc`/jump
- Call with stack not full: push (pc+1) mod 2^PC_W; sp++; then jump.
- Call with stack full: jump still taken; push dropped; sp unchanged; `stack_ovf` set.
- Return with stack not empty: sp−−; pc ← popped entry.
- Return with stack empty: pc ← pc+1; `stack_udf` set.
- If `s_call` and `s_ret` are asserted together, the return executes and the call is ignored.
- PC+1 wraps from 2^PC_W−1 to 0.
- `stack_ovf` and `stack_udf` clear only on reset.

## Timing
- All state updates on the rising `clk` edge: pc, sp, stack RAM, register file, z, c, fault flags.
- Zero-cycle combinational path from `instr` to the write-back value. One instruction per cycle.
- A register written in cycle n is visible to reads in cycle n+1.
- The flags written by an instruction are visible to the control unit in the next cycle.
- Reset (`reset`=0 at an edge) sets:
  - pc = 0, sp = 0
  - z = 0, c = 0
  - `stack_ovf` = 0, `stack_udf` = 0
- Reset overrides every enable in the same cycle.
- Stack and register-file contents are not cleared by reset, except r0 = 0.
- A mid-program reset discards all pending returns.

## Configuration
- `CD_CARRY_EN` defined: carry logic and the `c` register are present; `wec` loads `c`.
- `CD_CARRY_EN` undefined:
  - `c` is tied to 0 and `wec` is ignored.
  - Adder is DATA_W bits with no carry-out.
  - All other behaviour is identical.

## Structure
- Package `cd_pkg` holds:
  - ALU op localparams (`ALU_PASS` … `ALU_NEGB`).
  - Instruction field bit positions.
  - Register-address width (4).
- Sub-module `pila_retorno`: a STACK_DEPTH × PC_W LIFO with push/pop/full/empty outputs and sp of width log2(STACK_DEPTH)+1.
- The register file is inline or reuses the existing `regfile` generalised by a width parameter.

## Test plan
- **Reset:** `reset`=0 for 2 cycles with `s_call`=1 → pc=0, z=c=0, both fault flags 0; the first instruction after release is fetched at pc=0.
- **Immediate load and add:** load 8'hF0 into r1 and 8'h10 into r2 (`s_inm`=1, `we3`=1), then op 010 r1+r2 → r3 with `wez`=`wec`=1 → r3=0, z=1, c=1 (CD_CARRY_EN); c=0 with the macro undefined.
- **Subtract borrow:** r1=3, r2=5, op 011 → result 8'hFE, c=1, z=0.
- **Nested calls:** at pc=5 call 20, at pc=20 call 40, at 40 ret → pc=21; ret → pc=6; a third ret → pc=7 and `stack_udf`=1.
- **Stack overflow:** STACK_DEPTH=2, three nested calls → the third jump is taken and `stack_ovf`=1; the following two rets return to the two oldest return addresses.
- **Edge cases:**
  - Simultaneous `s_call`/`s_ret` → pop only, sp−1.
  - pc=2^PC_W−1 with `s_inc` → pc=0.
  - Write to r0 → reads 0.
